// File: rtl/mem_bus_arbiter.sv
// Shares one backing-memory port between the I-cache refill path and the D-cache refill/write-back path.
// Each grant runs a fixed LINE_WORDS-beat burst, and arbitration alternates between the two sides under contention.
module mem_bus_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST,
    input  logic              ICacheReq,
    input  logic [ADDR_W-1:0] ICacheAddr,
    output logic [31:0]       ICacheRdata,
    output logic              ICacheRvalid,
    output logic              ICacheDone,
    input  logic              DCacheReq,
    input  logic              DCacheWe,
    input  logic [ADDR_W-1:0] DCacheAddr,
    input  logic [31:0]       DCacheWdata,
    output logic              DCacheWready,
    output logic [31:0]       DCacheRdata,
    output logic              DCacheRvalid,
    output logic              DCacheDone,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWdata,
    input  logic              MemAck,
    input  logic [31:0]       MemRdata,
    output logic [1:0]        Grant,
    output logic              Busy
);

    localparam int                CNT_W     = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [1:0]        GNT_NONE  = 2'b00;
    localparam logic [1:0]        GNT_I     = 2'b01;
    localparam logic [1:0]        GNT_D     = 2'b10;

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t            state, state_next;
    logic [1:0]        grant, grant_next;
    logic [CNT_W-1:0]  beat, beat_next;
    logic [ADDR_W-1:0] base, base_next;
    logic              we, we_next;
    logic              last_d, last_d_next;
    logic              pick_d;
    logic              beat_ack;
    logic              last_beat;

    logic              i_vld_p1, d_vld_p1;
    logic [31:0]       i_rdata_p1, d_rdata_p1;

    // A beat only completes while a request is actually presented.
    assign beat_ack  = (state == BURST) && MemAck;
    assign last_beat = (beat == CNT_W'(LINE_WORDS - 1));

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        beat_next   = beat;
        base_next   = base;
        we_next     = we;
        last_d_next = last_d;
        pick_d      = 1'b0;
        case (state)
            IDLE: begin
                if (ICacheReq || DCacheReq) begin
                    // Under contention, the side that did not win last time wins now.
                    pick_d      = DCacheReq && (!ICacheReq || !last_d);
                    grant_next  = pick_d ? GNT_D : GNT_I;
                    base_next   = (pick_d ? DCacheAddr : ICacheAddr) & LINE_MASK;
                    we_next     = pick_d && DCacheWe;
                    beat_next   = '0;
                    last_d_next = pick_d;
                    state_next  = BURST;
                end
            end
            BURST: begin
                if (MemAck) begin
                    beat_next = beat + CNT_W'(1);
                    if (last_beat) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                grant_next = GNT_NONE;
                state_next = IDLE;
            end
            default: begin
                grant_next = GNT_NONE;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            state  <= IDLE;
            grant  <= GNT_NONE;
            beat   <= '0;
            base   <= '0;
            we     <= 1'b0;
            last_d <= 1'b0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            beat   <= beat_next;
            base   <= base_next;
            we     <= we_next;
            last_d <= last_d_next;
        end
    end

    // p1: read beats are registered toward the granted requester
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            i_vld_p1   <= 1'b0;
            d_vld_p1   <= 1'b0;
            i_rdata_p1 <= '0;
            d_rdata_p1 <= '0;
        end else begin
            i_vld_p1 <= beat_ack && !we && (grant == GNT_I);
            d_vld_p1 <= beat_ack && !we && (grant == GNT_D);
            if (beat_ack && !we && (grant == GNT_I)) begin
                i_rdata_p1 <= MemRdata;
            end
            if (beat_ack && !we && (grant == GNT_D)) begin
                d_rdata_p1 <= MemRdata;
            end
        end
    end

    assign MemReq       = (state == BURST);
    assign MemWe        = (state == BURST) && we;
    assign MemAddr      = base + ADDR_W'({beat, 2'b00});
    assign MemWdata     = DCacheWdata;
    assign DCacheWready = beat_ack && we;
    assign ICacheRvalid = i_vld_p1;
    assign ICacheRdata  = i_rdata_p1;
    assign DCacheRvalid = d_vld_p1;
    assign DCacheRdata  = d_rdata_p1;
    assign ICacheDone   = (state == DONE) && (grant == GNT_I);
    assign DCacheDone   = (state == DONE) && (grant == GNT_D);
    assign Grant        = grant;
    assign Busy         = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed burst sequences and a randomized scoreboard run.
module tb_mem_bus_arbiter;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq, dreq, dwe, mack;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [31:0] irdata, drdata, maddr, mwdata;
    logic        irvalid, idone, drvalid, ddone, dwready;
    logic        mreq, mwe, busy;
    logic [1:0]  grant;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .CPU_CLK(clk), .CPU_RST(rst),
        .ICacheReq(ireq), .ICacheAddr(iaddr), .ICacheRdata(irdata),
        .ICacheRvalid(irvalid), .ICacheDone(idone),
        .DCacheReq(dreq), .DCacheWe(dwe), .DCacheAddr(daddr), .DCacheWdata(dwdata),
        .DCacheWready(dwready), .DCacheRdata(drdata), .DCacheRvalid(drvalid),
        .DCacheDone(ddone),
        .MemReq(mreq), .MemWe(mwe), .MemAddr(maddr), .MemWdata(mwdata),
        .MemAck(mack), .MemRdata(mrdata),
        .Grant(grant), .Busy(busy)
    );

    typedef struct {
        logic        ireq;
        logic        ack;
        logic [31:0] rdata;
        logic        e_mreq;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_data;
        logic        e_done;
        logic [1:0]  e_grant;
        logic        e_busy;
    } vec_t;

    vec_t tbl[7];

    task automatic chkb(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", nm, a, e);
        end
    endtask

    task automatic chkv(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1; ireq = 1'b0; dreq = 1'b0; mack = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Both sides raise together from idle; exp is the side that must win.
    task automatic both_race(input logic [1:0] e);
        logic seen;
        seen = 1'b0;
        ireq = 1'b1; dreq = 1'b1; dwe = 1'b0; iaddr = 32'h7000; daddr = 32'h8000; mack = 1'b0;
        #1 chkv("race_idle_grant", 32'(grant), 32'h0);
        tick();
        mack = 1'b1;
        #1 chkv("race_grant", 32'(grant), 32'(e));
        for (int n = 0; n < 10; n++) begin
            if (idone || ddone) begin
                seen = 1'b1;
                chkb("race_idone", idone, e == 2'b01);
                chkb("race_ddone", ddone, e == 2'b10);
                break;
            end
            tick();
            #1;
        end
        chkb("race_done_seen", seen, 1'b1);
        ireq = 1'b0; dreq = 1'b0; mack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic        seen;
        logic [6:0]  pat;
        int          beats, vcnt, wcnt;
        int          first_dd, first_ig;
        logic        i_drop, d_drop;
        logic [1:0]  prev_g;
        logic [1:0]  gq[$];
        // reference model state for the random run
        int          owner, beats_left, m_wr, m_last_d;
        logic [31:0] m_base;
        logic        pi_vld, pd_vld, i_cool, d_cool, in_burst, in_done;
        logic [31:0] pi_data, pd_data;

        rst = 1'b1; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; mack = 1'b0;
        iaddr = '0; daddr = '0; dwdata = '0; mrdata = '0;
        tick();
        tick();
        #1;
        chkv("rst_grant", 32'(grant), 32'h0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_mreq", mreq, 1'b0);
        chkb("rst_mwe", mwe, 1'b0);
        chkb("rst_irvalid", irvalid, 1'b0);
        chkb("rst_drvalid", drvalid, 1'b0);
        chkb("rst_idone", idone, 1'b0);
        chkb("rst_ddone", ddone, 1'b0);
        chkb("rst_wready", dwready, 1'b0);
        chkv("rst_irdata", irdata, 32'h0);
        chkv("rst_drdata", drdata, 32'h0);
        chkv("rst_maddr", maddr, 32'h0);

        // I-only line refill, MemAck held high, stray ack while idle in cycle 0
        tbl[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 2'b00, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'hA0, 1'b1, 32'h100, 1'b0, 32'h00, 1'b0, 2'b01, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 32'hA1, 1'b1, 32'h104, 1'b1, 32'hA0, 1'b0, 2'b01, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 32'hA2, 1'b1, 32'h108, 1'b1, 32'hA1, 1'b0, 2'b01, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 32'hA3, 1'b1, 32'h10C, 1'b1, 32'hA2, 1'b0, 2'b01, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h000, 1'b1, 32'hA3, 1'b1, 2'b01, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 2'b00, 1'b0};
        rst = 1'b0;
        iaddr = 32'h0000_0104;
        for (int i = 0; i < 7; i++) begin
            ireq = tbl[i].ireq; mack = tbl[i].ack; mrdata = tbl[i].rdata;
            #1;
            chkb("vec_mreq", mreq, tbl[i].e_mreq);
            if (tbl[i].e_mreq) chkv("vec_maddr", maddr, tbl[i].e_addr);
            chkb("vec_mwe", mwe, 1'b0);
            chkb("vec_irvalid", irvalid, tbl[i].e_vld);
            if (tbl[i].e_vld) chkv("vec_irdata", irdata, tbl[i].e_data);
            chkb("vec_idone", idone, tbl[i].e_done);
            chkv("vec_grant", 32'(grant), 32'(tbl[i].e_grant));
            chkb("vec_busy", busy, tbl[i].e_busy);
            chkb("vec_drvalid", drvalid, 1'b0);
            chkb("vec_ddone", ddone, 1'b0);
            tick();
        end

        // D write-back with a gappy ack pattern (applied oldest bit first)
        pat = 7'b1110100;
        dreq = 1'b1; dwe = 1'b1; daddr = 32'h2000; mack = 1'b0;
        #1 chkv("wb_idle_grant", 32'(grant), 32'h0);
        tick();
        beats = 0; wcnt = 0;
        for (int k = 0; k < 7; k++) begin
            mack = pat[k];
            dwdata = 32'hD000 + 32'(beats);
            #1;
            chkb("wb_mreq", mreq, 1'b1);
            chkb("wb_mwe", mwe, 1'b1);
            chkv("wb_maddr", maddr, 32'h2000 + 32'(4 * beats));
            chkv("wb_mwdata", mwdata, dwdata);
            chkb("wb_wready", dwready, pat[k]);
            chkb("wb_drvalid", drvalid, 1'b0);
            chkb("wb_ddone", ddone, 1'b0);
            chkv("wb_grant", 32'(grant), 32'h2);
            if (dwready) wcnt++;
            if (pat[k]) beats++;
            tick();
        end
        mack = 1'b0;
        #1;
        chkb("wb_done", ddone, 1'b1);
        chkb("wb_done_mreq", mreq, 1'b0);
        chkb("wb_done_drvalid", drvalid, 1'b0);
        chkv("wb_done_grant", 32'(grant), 32'h2);
        chkv("wb_wready_count", 32'(wcnt), 32'd4);
        dreq = 1'b0;
        tick();
        #1 chkb("wb_after_busy", busy, 1'b0);
        tick();

        // Last winner was D, so a simultaneous pair goes to I, then to D
        both_race(2'b01);
        both_race(2'b10);

        // Contention straight after reset, both sides re-requesting continuously
        do_reset();
        iaddr = 32'h3000; daddr = 32'h401C; dwe = 1'b0; mack = 1'b1;
        i_drop = 1'b0; d_drop = 1'b0; prev_g = 2'b00;
        first_dd = -1; first_ig = -1;
        for (int c = 0; c < 40; c++) begin
            ireq = !i_drop; dreq = !d_drop;
            mrdata = 32'hC000 + 32'(c);
            #1;
            if (c == 1) begin
                chkv("ctn_first_grant", 32'(grant), 32'h2);
                chkv("ctn_first_addr", maddr, 32'h4010);
            end
            if (ddone && first_dd < 0) first_dd = c;
            if (grant == 2'b01 && first_ig < 0) begin
                first_ig = c;
                chkb("ctn_i_mreq", mreq, 1'b1);
                chkv("ctn_i_addr", maddr, 32'h3000);
            end
            if (grant != 2'b00 && prev_g == 2'b00) gq.push_back(grant);
            prev_g = grant;
            i_drop = idone; d_drop = ddone;
            tick();
        end
        chkv("ctn_first_ddone", 32'(first_dd), 32'd5);
        chkv("ctn_i_grant_gap", 32'(first_ig), 32'(first_dd + 2));
        chkb("ctn_grant_count", gq.size() >= 4, 1'b1);
        if (gq.size() >= 4) begin
            chkv("ctn_seq0", 32'(gq[0]), 32'h2);
            chkv("ctn_seq1", 32'(gq[1]), 32'h1);
            chkv("ctn_seq2", 32'(gq[2]), 32'h2);
            chkv("ctn_seq3", 32'(gq[3]), 32'h1);
        end

        // Reset during beat 2 of an I refill
        do_reset();
        ireq = 1'b1; iaddr = 32'h5008; mack = 1'b1; mrdata = 32'h55;
        tick();
        #1 chkv("rmb_beat0_addr", maddr, 32'h5000);
        tick();
        tick();
        rst = 1'b1;
        #1 chkv("rmb_beat2_addr", maddr, 32'h5008);
        tick();
        rst = 1'b0; ireq = 1'b0;
        #1;
        chkb("rmb_mreq", mreq, 1'b0);
        chkv("rmb_grant", 32'(grant), 32'h0);
        chkb("rmb_busy", busy, 1'b0);
        chkb("rmb_idone", idone, 1'b0);
        chkb("rmb_irvalid", irvalid, 1'b0);
        tick();
        ireq = 1'b1;
        #1 chkb("rmb_idone2", idone, 1'b0);
        tick();
        #1;
        chkb("rmb_restart_mreq", mreq, 1'b1);
        chkv("rmb_restart_addr", maddr, 32'h5000);
        chkv("rmb_restart_grant", 32'(grant), 32'h1);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (idone) begin
                seen = 1'b1;
                break;
            end
            tick();
            #1;
        end
        chkb("rmb_restart_done", seen, 1'b1);
        ireq = 1'b0;
        tick();
        tick();

        // Stray acks while idle, then a request dropped after its first beat
        mack = 1'b1;
        tick();
        #1;
        chkb("stray_irvalid", irvalid, 1'b0);
        chkb("stray_mreq", mreq, 1'b0);
        chkb("stray_busy", busy, 1'b0);
        tick();
        ireq = 1'b1; iaddr = 32'h6000;
        tick();
        beats = 0; vcnt = 0; seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            mrdata = 32'h60 + 32'(beats);
            if (n == 1) ireq = 1'b0;
            #1;
            if (irvalid) begin
                chkv("drop_irdata", irdata, 32'h60 + 32'(vcnt));
                vcnt++;
            end
            if (mreq) begin
                chkv("drop_maddr", maddr, 32'h6000 + 32'(4 * beats));
                beats++;
            end
            if (idone) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chkb("drop_done_seen", seen, 1'b1);
        chkv("drop_beats", 32'(beats), 32'd4);
        chkv("drop_valids", 32'(vcnt), 32'd4);
        mack = 1'b0;
        tick();

        // Randomized traffic against a transaction-level scoreboard
        do_reset();
        owner = 0; beats_left = 0; m_wr = 0; m_last_d = 0; m_base = '0;
        pi_vld = 1'b0; pd_vld = 1'b0; pi_data = '0; pd_data = '0;
        i_cool = 1'b0; d_cool = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (i_cool) ireq = 1'b0;
            else if (!ireq && $urandom_range(0, 3) == 0) begin
                ireq = 1'b1; iaddr = $urandom;
            end
            if (d_cool) dreq = 1'b0;
            else if (!dreq && $urandom_range(0, 3) == 0) begin
                dreq = 1'b1; daddr = $urandom; dwe = 1'($urandom_range(0, 1));
            end
            mack = ($urandom_range(0, 2) != 0);
            mrdata = $urandom;
            dwdata = $urandom;
            #1;
            in_burst = (owner != 0) && (beats_left > 0);
            in_done  = (owner != 0) && (beats_left == 0);
            chkb("rnd_mreq", mreq, in_burst);
            chkb("rnd_busy", busy, owner != 0);
            chkv("rnd_grant", 32'(grant), owner == 1 ? 32'h1 : (owner == 2 ? 32'h2 : 32'h0));
            if (in_burst) begin
                chkv("rnd_maddr", maddr, m_base + 32'(4 * (LW - beats_left)));
                chkb("rnd_mwe", mwe, m_wr != 0);
                if (m_wr != 0) chkv("rnd_mwdata", mwdata, dwdata);
            end else begin
                chkb("rnd_mwe_idle", mwe, 1'b0);
            end
            chkb("rnd_wready", dwready, in_burst && (m_wr != 0) && mack);
            chkb("rnd_idone", idone, in_done && owner == 1);
            chkb("rnd_ddone", ddone, in_done && owner == 2);
            chkb("rnd_irvalid", irvalid, pi_vld);
            if (pi_vld) chkv("rnd_irdata", irdata, pi_data);
            chkb("rnd_drvalid", drvalid, pd_vld);
            if (pd_vld) chkv("rnd_drdata", drdata, pd_data);
            i_cool = in_done && owner == 1;
            d_cool = in_done && owner == 2;
            pi_vld = 1'b0; pd_vld = 1'b0;
            if (owner == 0) begin
                if (ireq || dreq) begin
                    if (ireq && dreq) owner = m_last_d ? 1 : 2;
                    else owner = ireq ? 1 : 2;
                    m_base = (owner == 2 ? daddr : iaddr) & ~32'(LW * 4 - 1);
                    m_wr = (owner == 2 && dwe) ? 1 : 0;
                    m_last_d = (owner == 2) ? 1 : 0;
                    beats_left = LW;
                end
            end else if (beats_left > 0) begin
                if (mack) begin
                    if (m_wr == 0) begin
                        if (owner == 1) begin pi_vld = 1'b1; pi_data = mrdata; end
                        else begin pd_vld = 1'b1; pd_data = mrdata; end
                    end
                    beats_left--;
                end
            end else begin
                owner = 0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
